// File: rtl/uart_echo_engine.sv
// rtl/uart_echo_engine.sv - RX-to-TX FIFO echo controller with run-time flush policy
// Optional statistics counters are built when UART_ECHO_STATS_EN is defined.
module uart_echo_engine #(
    parameter int DATA_WIDTH  = 8,
    parameter int LEVEL_WIDTH = 5,
    parameter int FLUSH_TICKS = 27000000,
    parameter int THRESHOLD   = 12,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             mode,
    input  logic [DATA_WIDTH-1:0]  rx_data,
    input  logic                   rx_empty,
    input  logic                   rx_full,
    input  logic [LEVEL_WIDTH-1:0] rx_level,
    output logic                   rx_read,
    output logic [DATA_WIDTH-1:0]  tx_data,
    output logic                   tx_write,
    input  logic                   tx_full,
    output logic                   busy,
    output logic                   flush_tick,
    output logic [COUNT_WIDTH-1:0] echo_count,
    output logic [COUNT_WIDTH-1:0] flush_count
);
    localparam int                TICK_W      = $clog2(FLUSH_TICKS);
    localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(FLUSH_TICKS - 1);

    localparam logic [1:0] MODE_IMMEDIATE = 2'd0;
    localparam logic [1:0] MODE_TIMED     = 2'd1;
    localparam logic [1:0] MODE_THRESHOLD = 2'd2;
    localparam logic [1:0] MODE_OFF       = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              strobe_q, strobe_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic              start;

    assign flush_tick = (tick_q == '0);
    assign tick_d     = flush_tick ? TICK_RELOAD : tick_q - TICK_W'(1);

    always_comb begin
        start = 1'b0;
        case (mode)
            MODE_IMMEDIATE: start = !rx_empty;
            MODE_TIMED:     start = (flush_tick && !rx_empty) || rx_full;
            MODE_THRESHOLD: start = (rx_level >= LEVEL_WIDTH'(THRESHOLD)) || rx_full
                                    || (flush_tick && !rx_empty);
            default:        start = 1'b0;
        endcase
    end

    // The strobe is decided in DRAIN and presented during GAP, so the FIFO
    // flags have a full cycle to settle before the next DRAIN evaluation.
    always_comb begin
        state_d  = state_q;
        strobe_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (!rx_empty && !tx_full && mode != MODE_OFF) begin
                    strobe_d = 1'b1;
                    state_d  = S_GAP;
                end else if (rx_empty || mode == MODE_OFF) begin
                    state_d = S_IDLE;
                end
            end
            S_GAP:   state_d = S_DRAIN;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            strobe_q <= 1'b0;
            tick_q   <= TICK_RELOAD;
        end else begin
            state_q  <= state_d;
            strobe_q <= strobe_d;
            tick_q   <= tick_d;
        end
    end

    assign rx_read  = strobe_q;
    assign tx_write = strobe_q;
    assign tx_data  = rx_data;
    assign busy     = (state_q != S_IDLE);

`ifdef UART_ECHO_STATS_EN
    logic [COUNT_WIDTH-1:0] echo_q, echo_d;
    logic [COUNT_WIDTH-1:0] flush_q, flush_d;

    always_comb begin
        echo_d  = echo_q;
        flush_d = flush_q;
        if (strobe_q && echo_q != '1) echo_d = echo_q + COUNT_WIDTH'(1);
        if (state_q == S_IDLE && state_d == S_DRAIN) flush_d = flush_q + COUNT_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            echo_q  <= '0;
            flush_q <= '0;
        end else begin
            echo_q  <= echo_d;
            flush_q <= flush_d;
        end
    end

    assign echo_count  = echo_q;
    assign flush_count = flush_q;
`else
    assign echo_count  = '0;
    assign flush_count = '0;
`endif
endmodule

// File: tb/tb_uart_echo_engine.sv
// tb/tb_uart_echo_engine.sv - scoreboard bench for uart_echo_engine with an RX FIFO model
module tb_uart_echo_engine;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_empty = 1'b1;
    logic        rx_full = 1'b0;
    logic [4:0]  rx_level = 5'd0;
    logic        rx_read;
    logic [7:0]  tx_data;
    logic        tx_write;
    logic        tx_full;
    logic        busy;
    logic        flush_tick;
    logic [15:0] echo_count;
    logic [15:0] flush_count;

    int vectors = 0;
    int miscompares = 0;
    int strobes = 0;

    logic [7:0] rxq[$];
    logic [7:0] rx_in[$];
    logic [7:0] expq[$];

    always #5 clk = ~clk;

    uart_echo_engine #(
        .DATA_WIDTH (8),
        .LEVEL_WIDTH(5),
        .FLUSH_TICKS(100),
        .THRESHOLD  (4),
        .COUNT_WIDTH(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .rx_data    (rx_data),
        .rx_empty   (rx_empty),
        .rx_full    (rx_full),
        .rx_level   (rx_level),
        .rx_read    (rx_read),
        .tx_data    (tx_data),
        .tx_write   (tx_write),
        .tx_full    (tx_full),
        .busy       (busy),
        .flush_tick (flush_tick),
        .echo_count (echo_count),
        .flush_count(flush_count)
    );

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int stat(input int v);
`ifdef UART_ECHO_STATS_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    // Monitor and RX FIFO owner: pop/compare on a strobe, then accept new words.
    always @(negedge clk) begin
        if (rx_read || tx_write) begin
            check("strobe_pair", tx_write, rx_read);
            check("pop_on_empty", rx_empty, 0);
            check("push_on_full", tx_full, 0);
            if (expq.size() == 0) check("unexpected_word", 1, 0);
            else check("tx_data", tx_data, expq.pop_front());
            if (rxq.size() > 0) void'(rxq.pop_front());
            strobes++;
        end
        while (rx_in.size() > 0) rxq.push_back(rx_in.pop_front());
        rx_empty = (rxq.size() == 0);
        rx_full  = (rxq.size() == 16);
        rx_level = 5'(rxq.size());
        rx_data  = (rxq.size() > 0) ? rxq[0] : 8'h00;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] w);
        rx_in.push_back(w);
        expq.push_back(w);
    endtask

    task automatic wait_idle(input int start, output int n);
        n = start;
        for (int i = 0; i < 100; i++) begin
            step();
            if (!busy) return;
            n++;
        end
        check("idle_timeout", 1, 0);
    endtask

    task automatic wait_tick(input int budget, output int early);
        early = 0;
        for (int i = 0; i < budget; i++) begin
            if (flush_tick) return;
            if (busy || rx_read) early++;
            step();
        end
        check("tick_timeout", 1, 0);
    endtask

    task automatic wait_drain_after(input int target);
        for (int i = 0; i < 40; i++) begin
            if (strobes >= target && busy && !rx_read) return;
            step();
        end
        check("drain_wait_timeout", 1, 0);
    endtask

    initial begin
        int n;
        int e;
        int s;
        rst = 1'b1;
        mode = 2'd0;
        tx_full = 1'b0;
        repeat (3) step();
        check("rst_rx_read", rx_read, 0);
        check("rst_tx_write", tx_write, 0);
        check("rst_busy", busy, 0);
        check("rst_flush_tick", flush_tick, 0);
        check("rst_echo_count", echo_count, 0);
        check("rst_flush_count", flush_count, 0);
        rst = 1'b0;

        // IMMEDIATE: three words, strobes two cycles apart
        step();
        step();
        push(8'h41); push(8'h42); push(8'h43);
        step();
        check("imm_drain_entry", busy, 1);
        check("imm_no_early_strobe", rx_read, 0);
        step();
        check("imm_strobe_latency", rx_read, 1);
        wait_idle(2, n);
        check("imm_drain_cycles", n, 7);
        check("imm_strobes", strobes, 3);
        check("imm_echo_count", echo_count, stat(3));
        check("imm_flush_count", flush_count, stat(1));

        // TIMED: a partial batch waits for the tick
        mode = 2'd1;
        wait_tick(200, e);
        step();
        for (int i = 0; i < 5; i++) push(8'h50 + 8'(i));
        step();
        wait_tick(120, e);
        check("timed_no_early", e, 0);
        step();
        check("timed_drain_entry", busy, 1);
        wait_idle(1, n);
        check("timed_drain_cycles", n, 11);
        check("timed_strobes", strobes, 8);
        check("timed_flush_count", flush_count, stat(2));

        // TIMED: full RX forces a drain without the tick
        for (int i = 0; i < 16; i++) push(8'h70 + 8'(i));
        step();
        check("full_drain_entry", busy, 1);
        wait_idle(1, n);
        check("full_drain_cycles", n, 33);
        check("full_strobes", strobes, 24);
        check("full_echo_count", echo_count, stat(24));
        check("full_flush_count", flush_count, stat(3));

        // THRESHOLD = 4
        mode = 2'd2;
        wait_tick(200, e);
        step();
        push(8'h80); push(8'h81); push(8'h82);
        e = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (busy || rx_read) e++;
        end
        check("thr_below_level", e, 0);
        push(8'h83);
        step();
        check("thr_entry", busy, 1);
        wait_idle(1, n);
        check("thr_drain_cycles", n, 9);
        check("thr_strobes", strobes, 28);
        push(8'h90); push(8'h91);
        step();
        wait_tick(120, e);
        check("thr_timeout_no_early", e, 0);
        step();
        check("thr_timeout_entry", busy, 1);
        wait_idle(1, n);
        check("thr_timeout_cycles", n, 5);
        check("thr_flush_count", flush_count, stat(5));

        // TX stall mid-drain
        mode = 2'd0;
        for (int i = 0; i < 6; i++) push(8'hA0 + 8'(i));
        wait_drain_after(31);
        tx_full = 1'b1;
        e = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (rx_read) e++;
            if (!busy) e++;
        end
        check("stall_hold", e, 0);
        tx_full = 1'b0;
        wait_idle(0, n);
        check("stall_strobes", strobes, 36);
        check("stall_flush_count", flush_count, stat(6));
        check("stall_scoreboard_empty", expq.size(), 0);

        // OFF mid-drain
        for (int i = 0; i < 6; i++) push(8'hB0 + 8'(i));
        wait_drain_after(38);
        mode = 2'd3;
        s = strobes;
        wait_idle(0, n);
        check("off_extra_strobes", (strobes - s) <= 1, 1);
        check("off_rx_level", rx_level, 4);
        check("off_flush_count", flush_count, stat(7));

        // Reset mid-drain
        mode = 2'd0;
        wait_drain_after(39);
        rst = 1'b1;
        step();
        check("mid_rst_rx_read", rx_read, 0);
        check("mid_rst_tx_write", tx_write, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_flush_tick", flush_tick, 0);
        check("mid_rst_echo_count", echo_count, 0);
        check("mid_rst_flush_count", flush_count, 0);
        check("mid_rst_head_kept", rx_data, 8'hB3);
        check("mid_rst_rx_level", rx_level, 3);
        rst = 1'b0;
        step();
        check("post_rst_entry", busy, 1);
        wait_idle(1, n);
        check("post_rst_drain_cycles", n, 7);
        check("post_rst_strobes", strobes, 42);
        check("post_rst_echo_count", echo_count, stat(3));
        check("post_rst_flush_count", flush_count, stat(1));
        check("final_scoreboard_empty", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
